gat_stage_scheduler: RTL and testbench



---
 rtl/gat_sched_pkg.sv | 36 +++
 rtl/gat_sched_watchdog.sv | 31 +++
 rtl/gat_stage_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_gat_stage_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_sched_pkg.sv
// rtl/gat_sched_pkg.sv - shared stage/state types for the GAT stage scheduler
package gat_sched_pkg;

    localparam int STAGE_NUM = 4;

    typedef enum logic [1:0] {
        STG_SPMM = 2'd0,
        STG_DMVM = 2'd1,
        STG_SM   = 2'd2,
        STG_AGGR = 2'd3
    } stage_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SPMM = 3'd1,
        ST_DMVM = 3'd2,
        ST_SM   = 3'd3,
        ST_AGGR = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // Stage code of a compute state; only meaningful for the four stage states.
    function automatic stage_e state_to_stage(input state_e s);
        case (s)
            ST_DMVM: return STG_DMVM;
            ST_SM:   return STG_SM;
            ST_AGGR: return STG_AGGR;
            default: return STG_SPMM;
        endcase
    endfunction

    function automatic logic is_stage_state(input state_e s);
        return (s == ST_SPMM) || (s == ST_DMVM) || (s == ST_SM) || (s == ST_AGGR);
    endfunction

endpackage

// File: rtl/gat_sched_watchdog.sv
// rtl/gat_sched_watchdog.sv - per-stage watchdog counter with clear-on-entry and expiry flag
module gat_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Count cycles spent in the current stage; restart from zero on every stage entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is flagged in the TIMEOUT_CYCLES-th cycle of the stage, so the error lands one cycle later.
    assign o_expired = i_run && (r_cnt == LIMIT);

endmodule

// File: rtl/gat_stage_scheduler.sv
// rtl/gat_stage_scheduler.sv - GAT layer/stage sequencer; optional perf counters via GAT_SCHED_PERF_CNT_EN
module gat_stage_scheduler
    import gat_sched_pkg::*;
#(
    parameter int NUM_LAYERS     = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 32,
    localparam int LW            = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_stage_o,
    output logic [LW-1:0]    layer_o,
    output logic             spmm_vld_o,
    input  logic             spmm_rdy_i,
    output logic             dmvm_vld_o,
    input  logic             dmvm_rdy_i,
    output logic             sm_vld_o,
    input  logic             sm_rdy_i,
    output logic             aggr_vld_o,
    input  logic             aggr_rdy_i,
    input  logic [1:0]       perf_sel_i,
    output logic [CNT_W-1:0] perf_cnt_o
);

    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [LW-1:0]          r_layer;
    logic [LW-1:0]          w_layer_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic [1:0]             r_err_stage;
    logic [1:0]             w_err_stage_nxt;
    logic                   r_busy;
    logic [STAGE_NUM-1:0]   r_vld;
    logic [STAGE_NUM-1:0]   w_vld_nxt;
    logic                   w_expired;
    logic                   w_in_stage;
    logic                   w_stage_entry;
    logic                   w_stage_rdy;
    logic                   w_start_acc;

    assign w_in_stage    = is_stage_state(r_state);
    assign w_stage_entry = (w_state_nxt != r_state);
    assign w_start_acc   = (r_state == ST_IDLE) && start_i && !abort_i;

    // Only the rdy belonging to the active stage counts; all others are ignored.
    always_comb begin
        w_stage_rdy = 1'b0;
        case (r_state)
            ST_SPMM: w_stage_rdy = spmm_rdy_i;
            ST_DMVM: w_stage_rdy = dmvm_rdy_i;
            ST_SM:   w_stage_rdy = sm_rdy_i;
            ST_AGGR: w_stage_rdy = aggr_rdy_i;
            default: w_stage_rdy = 1'b0;
        endcase
    end

    gat_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_stage_entry),
        .i_run     (w_in_stage),
        .o_expired (w_expired)
    );

    // Next-state logic: abort beats rdy, rdy beats watchdog expiry.
    always_comb begin
        w_state_nxt     = r_state;
        w_layer_nxt     = r_layer;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;
        w_err_stage_nxt = r_err_stage;
        if (abort_i) begin
            w_state_nxt     = ST_IDLE;
            w_err_nxt       = 1'b0;
            w_err_stage_nxt = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = ST_SPMM;
                        w_layer_nxt = '0;
                    end
                end
                ST_SPMM, ST_DMVM, ST_SM, ST_AGGR: begin
                    if (w_stage_rdy) begin
                        case (r_state)
                            ST_SPMM: w_state_nxt = ST_DMVM;
                            ST_DMVM: w_state_nxt = ST_SM;
                            ST_SM:   w_state_nxt = ST_AGGR;
                            default: begin
                                if (r_layer == LAST_LAYER) begin
                                    w_state_nxt = ST_IDLE;
                                    w_done_nxt  = 1'b1;
                                end else begin
                                    w_state_nxt = ST_SPMM;
                                    w_layer_nxt = r_layer + 1'b1;
                                end
                            end
                        endcase
                    end else if (w_expired) begin
                        w_state_nxt     = ST_ERR;
                        w_err_nxt       = 1'b1;
                        w_err_stage_nxt = state_to_stage(r_state);
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // One-hot stage valids decoded from the next state so the outputs come straight from flops.
    always_comb begin
        w_vld_nxt = '0;
        case (w_state_nxt)
            ST_SPMM: w_vld_nxt[STG_SPMM] = 1'b1;
            ST_DMVM: w_vld_nxt[STG_DMVM] = 1'b1;
            ST_SM:   w_vld_nxt[STG_SM]   = 1'b1;
            ST_AGGR: w_vld_nxt[STG_AGGR] = 1'b1;
            default: w_vld_nxt = '0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_layer     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_stage <= 2'd0;
            r_busy      <= 1'b0;
            r_vld       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_layer     <= w_layer_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_stage <= w_err_stage_nxt;
            r_busy      <= is_stage_state(w_state_nxt);
            r_vld       <= w_vld_nxt;
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign err_stage_o = r_err_stage;
    assign layer_o     = r_layer;
    assign spmm_vld_o  = r_vld[STG_SPMM];
    assign dmvm_vld_o  = r_vld[STG_DMVM];
    assign sm_vld_o    = r_vld[STG_SM];
    assign aggr_vld_o  = r_vld[STG_AGGR];

`ifdef GAT_SCHED_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf [STAGE_NUM];

    // Saturating per-stage valid-cycle counters, cleared when a run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGE_NUM; s++) r_perf[s] <= '0;
        end else if (w_start_acc) begin
            for (int s = 0; s < STAGE_NUM; s++) r_perf[s] <= '0;
        end else begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (r_vld[s] && (r_perf[s] != {CNT_W{1'b1}})) r_perf[s] <= r_perf[s] + 1'b1;
            end
        end
    end

    assign perf_cnt_o = r_perf[perf_sel_i];
`else
    logic w_unused_perf;
    assign w_unused_perf = (^perf_sel_i) ^ w_start_acc;
    assign perf_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_gat_stage_scheduler.sv
// tb/tb_gat_stage_scheduler.sv - directed self-checking bench for gat_stage_scheduler
module tb_gat_stage_scheduler;

    localparam int NL = 2;
    localparam int TO = 16;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [1:0]    err_stage_o;
    logic [0:0]    layer_o;
    logic          spmm_vld_o, dmvm_vld_o, sm_vld_o, aggr_vld_o;
    logic          spmm_rdy_i, dmvm_rdy_i, sm_rdy_i, aggr_rdy_i;
    logic [1:0]    perf_sel_i;
    logic [CW-1:0] perf_cnt_o;
    logic [3:0]    vld;

    int n_checks;
    int n_errors;

    assign vld = {aggr_vld_o, sm_vld_o, dmvm_vld_o, spmm_vld_o};

    gat_stage_scheduler #(
        .NUM_LAYERS    (NL),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_stage_o(err_stage_o),
        .layer_o    (layer_o),
        .spmm_vld_o (spmm_vld_o),
        .spmm_rdy_i (spmm_rdy_i),
        .dmvm_vld_o (dmvm_vld_o),
        .dmvm_rdy_i (dmvm_rdy_i),
        .sm_vld_o   (sm_vld_o),
        .sm_rdy_i   (sm_rdy_i),
        .aggr_vld_o (aggr_vld_o),
        .aggr_rdy_i (aggr_rdy_i),
        .perf_sel_i (perf_sel_i),
        .perf_cnt_o (perf_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rdy(input int s, input logic v);
        case (s)
            0: spmm_rdy_i = v;
            1: dmvm_rdy_i = v;
            2: sm_rdy_i   = v;
            default: aggr_rdy_i = v;
        endcase
    endtask

    // Hold stage s for three cycles, returning its rdy in the third.
    task automatic run_stage(input int s, input int lay);
        logic [3:0] exp_vld;
        exp_vld = 4'b0001 << s;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("vld_s%0d_l%0d_k%0d", s, lay, k), 32'(vld), 32'(exp_vld));
            chk($sformatf("layer_s%0d_l%0d_k%0d", s, lay, k), 32'(layer_o), 32'(lay));
            chk($sformatf("busy_s%0d_l%0d_k%0d", s, lay, k), 32'(busy_o), 32'd1);
            chk($sformatf("nodone_s%0d_l%0d_k%0d", s, lay, k), 32'(done_o), 32'd0);
            if (k == 2) set_rdy(s, 1'b1);
            tick();
            set_rdy(s, 1'b0);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        spmm_rdy_i = 1'b0;
        dmvm_rdy_i = 1'b0;
        sm_rdy_i   = 1'b0;
        aggr_rdy_i = 1'b0;
        perf_sel_i = 2'd0;
        tick();
        tick();

        // Reset values
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_stage", 32'(err_stage_o), 32'd0);
        chk("rst_layer", 32'(layer_o), 32'd0);
        chk("rst_perf", perf_cnt_o, 32'd0);
        rst = 1'b0;
        tick();

        // Full two-layer run, rdy in the third cycle of each vld
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int l = 0; l < NL; l++) begin
            for (int s = 0; s < 4; s++) run_stage(s, l);
        end
        chk("run_done", 32'(done_o), 32'd1);
        chk("run_busy_low", 32'(busy_o), 32'd0);
        chk("run_vld_low", 32'(vld), 32'd0);
        tick();
        chk("run_done_pulse", 32'(done_o), 32'd0);

        for (int p = 0; p < 4; p++) begin
            perf_sel_i = 2'(p);
            #1;
`ifdef GAT_SCHED_PERF_CNT_EN
            chk($sformatf("perf_%0d", p), perf_cnt_o, 32'd6);
`else
            chk($sformatf("perf_%0d", p), perf_cnt_o, 32'd0);
`endif
        end

        // Watchdog on SM
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_stage(0, 0);
        run_stage(1, 0);
        chk("wd_sm_vld", 32'(vld), 32'b0100);
        repeat (15) tick();
        chk("wd_pre_err", 32'(err_o), 32'd0);
        chk("wd_pre_vld", 32'(vld), 32'b0100);
        tick();
        chk("wd_err", 32'(err_o), 32'd1);
        chk("wd_err_stage", 32'(err_stage_o), 32'd2);
        chk("wd_vld_low", 32'(vld), 32'd0);
        chk("wd_busy_low", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("wd_start_ign_vld", 32'(vld), 32'd0);
        chk("wd_start_ign_err", 32'(err_o), 32'd1);
        chk("wd_start_ign_busy", 32'(busy_o), 32'd0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("wd_abort_err", 32'(err_o), 32'd0);
        chk("wd_abort_stage", 32'(err_stage_o), 32'd0);
        chk("wd_abort_busy", 32'(busy_o), 32'd0);

        // rdy in the expiry cycle wins over the watchdog
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_stage(0, 0);
        run_stage(1, 0);
        repeat (15) tick();
        sm_rdy_i = 1'b1;
        tick();
        sm_rdy_i = 1'b0;
        chk("race_err", 32'(err_o), 32'd0);
        chk("race_vld", 32'(vld), 32'b1000);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("race_abort_vld", 32'(vld), 32'd0);

        // Foreign rdy ignored, then abort together with final AGGR rdy
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        dmvm_rdy_i = 1'b1;
        tick();
        dmvm_rdy_i = 1'b0;
        chk("ign_dmvm", 32'(vld), 32'b0001);
        aggr_rdy_i = 1'b1;
        tick();
        aggr_rdy_i = 1'b0;
        chk("ign_aggr", 32'(vld), 32'b0001);
        run_stage(0, 0);
        run_stage(1, 0);
        run_stage(2, 0);
        run_stage(3, 0);
        run_stage(0, 1);
        run_stage(1, 1);
        run_stage(2, 1);
        chk("abrt_aggr_vld", 32'(vld), 32'b1000);
        chk("abrt_layer", 32'(layer_o), 32'd1);
        aggr_rdy_i = 1'b1;
        abort_i    = 1'b1;
        tick();
        aggr_rdy_i = 1'b0;
        abort_i    = 1'b0;
        chk("abrt_done", 32'(done_o), 32'd0);
        chk("abrt_busy", 32'(busy_o), 32'd0);
        chk("abrt_vld", 32'(vld), 32'd0);
        tick();
        chk("abrt_done_late", 32'(done_o), 32'd0);
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abst_vld", 32'(vld), 32'd0);
        chk("abst_busy", 32'(busy_o), 32'd0);
        tick();
        chk("abst_vld2", 32'(vld), 32'd0);

        // Asynchronous reset during the last layer's AGGR
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int s = 0; s < 4; s++) run_stage(s, 0);
        for (int s = 0; s < 3; s++) run_stage(s, 1);
        chk("ar_aggr", 32'(vld), 32'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_vld", 32'(vld), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_layer", 32'(layer_o), 32'd0);
        chk("ar_done", 32'(done_o), 32'd0);
        chk("ar_perf", perf_cnt_o, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_no_done", 32'(done_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_stage(0, 0);
        run_stage(1, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("ar_end_vld", 32'(vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
